// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundles the FU-result request side, branch-resolution inputs and
// the CDB output lanes of cdb_arbiter.
//   req_valid/req_tag/req_data/req_bmask : per-FU result offered (master -> arbiter)
//   req_ready                            : per-FU slot can accept (~busy) (arbiter -> master)
//   br_id/br_task                        : one-hot branch and task (0 NOTHING, 1 CLEAR, 2 SQUASH)
//   cdb_valid/cdb_tag/cdb_data/cdb_src   : per-lane CDB broadcast (arbiter -> master)
// Modports: master (FU / test side), slave (arbiter side).
interface cdb_arbiter_if #(
  parameter int unsigned N       = 2,
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BR_MASK = 4
);
  localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*TAG_W-1:0]   req_tag;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ*BR_MASK-1:0] req_bmask;
  logic [NUM_REQ-1:0]         req_ready;
  logic [BR_MASK-1:0]         br_id;
  logic [1:0]                 br_task;
  logic [N-1:0]               cdb_valid;
  logic [N*TAG_W-1:0]         cdb_tag;
  logic [N*DATA_W-1:0]        cdb_data;
  logic [N*SRC_W-1:0]         cdb_src;

  modport master (
    output req_valid, req_tag, req_data, req_bmask, br_id, br_task,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_data, req_bmask, br_id, br_task,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares N common-data-bus lanes among NUM_REQ functional units.
// Each FU result is captured into a 1-entry slot; a round-robin scan starting at
// rr_ptr grants up to N eligible slots per cycle onto lanes 0..N-1 in scan order.
// Branch SQUASH kills slots/incoming results whose mask hits br_id; CLEAR drops
// the br_id bit from held and captured masks.
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   bus (slave)        : request/ready, branch inputs, CDB lanes (see cdb_arbiter_if)
//   perf_grants        : 32b saturating total grant count     (CDB_ARB_PERF_EN only)
//   perf_conflict      : 32b saturating count of cycles with an eligible
//                        but ungranted slot                   (CDB_ARB_PERF_EN only)
// Optional feature macro: CDB_ARB_PERF_EN.
module cdb_arbiter #(
  parameter int unsigned N       = 2,
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BR_MASK = 4
) (
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]  perf_grants,
  output logic [31:0]  perf_conflict
`endif
);

  localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    BR_NOTHING = 2'd0,
    BR_CLEAR   = 2'd1,
    BR_SQUASH  = 2'd2
  } br_task_e;

  br_task_e           br_task;
  logic               squash;
  logic [BR_MASK-1:0] clear_bits;

  logic [NUM_REQ-1:0] slot_valid;
  logic [TAG_W-1:0]   slot_tag   [NUM_REQ];
  logic [DATA_W-1:0]  slot_data  [NUM_REQ];
  logic [BR_MASK-1:0] slot_bmask [NUM_REQ];
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   rr_next;

  logic [NUM_REQ-1:0] killed;
  logic [NUM_REQ-1:0] dropped;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] granted;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] capture;

  assign br_task    = br_task_e'(bus.br_task);
  assign squash     = (br_task == BR_SQUASH);
  assign clear_bits = (br_task == BR_CLEAR) ? bus.br_id : '0;

  always_comb begin
    killed  = '0;
    dropped = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      killed[r]  = squash && ((slot_bmask[r] & bus.br_id) != '0);
      dropped[r] = squash && ((bus.req_bmask[r*BR_MASK +: BR_MASK] & bus.br_id) != '0);
    end
  end

  assign eligible = slot_valid & ~killed;

  // Round-robin scan: walk from rr_ptr with wrap, filling lanes in scan order.
  always_comb begin
    int unsigned lane;
    int unsigned idx;
    granted       = '0;
    bus.cdb_valid = '0;
    bus.cdb_tag   = '0;
    bus.cdb_data  = '0;
    bus.cdb_src   = '0;
    rr_next       = rr_ptr;
    lane          = 0;
    idx           = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[idx] && (lane < N)) begin
        granted[idx]                          = 1'b1;
        bus.cdb_valid[lane]                   = 1'b1;
        bus.cdb_tag[lane*TAG_W +: TAG_W]      = slot_tag[idx];
        bus.cdb_data[lane*DATA_W +: DATA_W]   = slot_data[idx];
        bus.cdb_src[lane*SRC_W +: SRC_W]      = SRC_W'(idx);
        rr_next = (idx == NUM_REQ - 1) ? '0 : SRC_W'(idx + 1);
        lane    = lane + 1;
      end
    end
  end

  // A slot frees up the same cycle it is granted or killed, so it can be refilled.
  assign ready         = ~slot_valid | granted | killed;
  assign bus.req_ready = ready;
  assign capture       = bus.req_valid & ready & ~dropped;

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
    end else begin
      rr_ptr <= rr_next;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (capture[r]) begin
          slot_valid[r] <= 1'b1;
          slot_tag[r]   <= bus.req_tag[r*TAG_W +: TAG_W];
          slot_data[r]  <= bus.req_data[r*DATA_W +: DATA_W];
          slot_bmask[r] <= bus.req_bmask[r*BR_MASK +: BR_MASK] & ~clear_bits;
        end else if (granted[r] || killed[r]) begin
          slot_valid[r] <= 1'b0;
        end else begin
          slot_bmask[r] <= slot_bmask[r] & ~clear_bits;
        end
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic [31:0] grant_cnt;
  logic [32:0] grants_sum;
  logic        conflict;

  always_comb begin
    grant_cnt = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      grant_cnt = grant_cnt + 32'(granted[r]);
    end
  end

  assign grants_sum = {1'b0, perf_grants} + {1'b0, grant_cnt};
  assign conflict   = (eligible & ~granted) != '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grants   <= '0;
      perf_conflict <= '0;
    end else begin
      perf_grants <= grants_sum[32] ? '1 : grants_sum[31:0];
      if (conflict && (perf_conflict != '1)) perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed test of cdb_arbiter with N=2, NUM_REQ=4, BR_MASK=2.
module tb_cdb_arbiter;
  localparam int unsigned N       = 2;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BR_MASK = 2;

  localparam logic [1:0] T_NOTHING = 2'd0;
  localparam logic [1:0] T_CLEAR   = 2'd1;
  localparam logic [1:0] T_SQUASH  = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cdb_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W),
                   .BR_MASK(BR_MASK)) bus ();

`ifdef CDB_ARB_PERF_EN
  logic [31:0] perf_grants;
  logic [31:0] perf_conflict;
`endif

  cdb_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W),
                .BR_MASK(BR_MASK)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_grants   (perf_grants),
    .perf_conflict (perf_conflict)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;
  int gcnt   [NUM_REQ];
  int gap    [NUM_REQ];
  int maxgap [NUM_REQ];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input int r, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data,
                     input logic [BR_MASK-1:0] bm);
    bus.req_valid[r]                     = 1'b1;
    bus.req_tag[r*TAG_W +: TAG_W]        = tag;
    bus.req_data[r*DATA_W +: DATA_W]     = data;
    bus.req_bmask[r*BR_MASK +: BR_MASK]  = bm;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
    bus.req_bmask = '0;
    bus.br_id     = '0;
    bus.br_task   = T_NOTHING;

    // Reset state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("reset_cdb_valid", bus.cdb_valid, 2'b00);
    check("reset_req_ready", bus.req_ready, 4'b1111);
    check("reset_rr_ptr",    dut.rr_ptr, 0);
    check("reset_cdb_tag",   bus.cdb_tag, 0);
    check("reset_cdb_src",   bus.cdb_src, 0);
`ifdef CDB_ARB_PERF_EN
    check("reset_perf_grants", perf_grants, 0);
`endif

    // Single result: appears on lane 0 the cycle after capture
    put(0, 6'd7, 32'hA5A5_0007, 2'b00);
    #1;
    check("single_ready_c0", bus.req_ready, 4'b1111);
    tick();
    bus.req_valid = '0;
    #1;
    check("single_cdb_valid", bus.cdb_valid, 2'b01);
    check("single_tag0",      bus.cdb_tag[TAG_W-1:0], 6'd7);
    check("single_src0",      bus.cdb_src[1:0], 2'd0);
    check("single_data0",     bus.cdb_data[DATA_W-1:0], 32'hA5A5_0007);
    check("single_ready_c1",  bus.req_ready, 4'b1111);
    tick();
    check("single_idle",      bus.cdb_valid, 2'b00);
    check("single_rr_ptr",    dut.rr_ptr, 1);

    // Fill all four slots at once, FUs 2/3 then hold new results
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < 4; r++) put(r, 6'(r + 1), 32'(100 + r), 2'b00);
    tick();
    bus.req_valid = '0;
    put(2, 6'd13, 32'd113, 2'b00);
    put(3, 6'd14, 32'd114, 2'b00);
    #1;
    check("fill_c1_valid", bus.cdb_valid, 2'b11);
    check("fill_c1_tag0",  bus.cdb_tag[5:0], 6'd1);
    check("fill_c1_tag1",  bus.cdb_tag[11:6], 6'd2);
    check("fill_c1_src",   bus.cdb_src, 4'b0100);
    check("fill_c1_ready", bus.req_ready, 4'b0011);
    tick();
    check("fill_c2_tag0",  bus.cdb_tag[5:0], 6'd3);
    check("fill_c2_tag1",  bus.cdb_tag[11:6], 6'd4);
    check("fill_c2_src",   bus.cdb_src, 4'b1110);
    check("fill_c2_ready", bus.req_ready, 4'b1111);
    tick();
    bus.req_valid = '0;
    #1;
    check("fill_c3_tag0",  bus.cdb_tag[5:0], 6'd13);
    check("fill_c3_tag1",  bus.cdb_tag[11:6], 6'd14);
    check("fill_c3_src",   bus.cdb_src, 4'b1110);
    tick();
    check("fill_c4_valid", bus.cdb_valid, 2'b00);
    check("fill_c4_rr",    dut.rr_ptr, 0);

    // Squash br_id=01 on masks 01,10,00,01; incoming FU0 result with mask 01 dropped
    put(0, 6'd21, 32'd21, 2'b01);
    put(1, 6'd22, 32'd22, 2'b10);
    put(2, 6'd23, 32'd23, 2'b00);
    put(3, 6'd24, 32'd24, 2'b01);
    tick();
    bus.req_valid = '0;
    bus.br_task   = T_SQUASH;
    bus.br_id     = 2'b01;
    put(0, 6'd25, 32'd25, 2'b01);
    #1;
    check("squash_valid", bus.cdb_valid, 2'b11);
    check("squash_tag0",  bus.cdb_tag[5:0], 6'd22);
    check("squash_tag1",  bus.cdb_tag[11:6], 6'd23);
    check("squash_src",   bus.cdb_src, 4'b1001);
    check("squash_ready", bus.req_ready, 4'b1111);
    tick();
    bus.req_valid = '0;
    bus.br_task   = T_NOTHING;
    bus.br_id     = '0;
    #1;
    check("squash_after_valid", bus.cdb_valid, 2'b00);
    check("squash_after_ready", bus.req_ready, 4'b1111);
    check("squash_after_rr",    dut.rr_ptr, 3);

    // Clear br_id=10: held slot 2 and captured slot 3 lose the bit, survive later squash
    put(0, 6'd40, 32'd40, 2'b10);
    put(1, 6'd41, 32'd41, 2'b10);
    put(2, 6'd42, 32'd42, 2'b10);
    tick();
    bus.req_valid = '0;
    bus.br_task   = T_CLEAR;
    bus.br_id     = 2'b10;
    put(3, 6'd43, 32'd43, 2'b10);
    #1;
    check("clear_valid", bus.cdb_valid, 2'b11);
    check("clear_tag0",  bus.cdb_tag[5:0], 6'd40);
    check("clear_tag1",  bus.cdb_tag[11:6], 6'd41);
    check("clear_src",   bus.cdb_src, 4'b0100);
    check("clear_ready", bus.req_ready, 4'b1011);
    tick();
    bus.req_valid = '0;
    bus.br_task   = T_SQUASH;
    bus.br_id     = 2'b10;
    #1;
    check("clear_sq_valid", bus.cdb_valid, 2'b11);
    check("clear_sq_tag0",  bus.cdb_tag[5:0], 6'd42);
    check("clear_sq_tag1",  bus.cdb_tag[11:6], 6'd43);
    check("clear_sq_src",   bus.cdb_src, 4'b1110);
    tick();
    bus.br_task = T_NOTHING;
    bus.br_id   = '0;
    #1;
    check("clear_after_valid", bus.cdb_valid, 2'b00);

    // Continuous streaming from all four FUs for 8 cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      put(r, 6'(r + 1), 32'(200 + r), 2'b00);
      gcnt[r]   = 0;
      gap[r]    = 0;
      maxgap[r] = 0;
    end
    tick();
    for (int k = 1; k <= 8; k++) begin
      #1;
      check("stream_valid", bus.cdb_valid, 2'b11);
      check("stream_src",   bus.cdb_src, (k % 2 == 1) ? 4'b0100 : 4'b1110);
      for (int r = 0; r < 4; r++) begin
        if ((bus.cdb_valid[0] && (bus.cdb_src[1:0] == 2'(r))) ||
            (bus.cdb_valid[1] && (bus.cdb_src[3:2] == 2'(r)))) begin
          gcnt[r]++;
          gap[r] = 0;
        end else begin
          gap[r]++;
          if (gap[r] > maxgap[r]) maxgap[r] = gap[r];
        end
      end
      tick();
    end
    for (int r = 0; r < 4; r++) begin
      check("stream_grants_per_fu", gcnt[r], 4);
      check("stream_max_gap",       maxgap[r], 1);
    end
`ifdef CDB_ARB_PERF_EN
    check("perf_grants_16",  perf_grants, 32'd16);
    check("perf_conflict_8", perf_conflict, 32'd8);
`endif

    // Reset while slots are full discards held results
    bus.req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midreset_valid", bus.cdb_valid, 2'b00);
    check("midreset_ready", bus.req_ready, 4'b1111);
    check("midreset_rr",    dut.rr_ptr, 0);
`ifdef CDB_ARB_PERF_EN
    check("midreset_perf",  perf_grants, 32'd0);
`endif
    tick();
    check("midreset_idle",  bus.cdb_valid, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
